// File: rtl/keysched_pkg.sv
// Shared types and mode constants for the AES round-key sequencer.
package keysched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        EXPAND
    } state_e;

    localparam int AES128_KEY_WORDS = 1;
    localparam int AES128_NR        = 10;
    localparam int AES256_KEY_WORDS = 2;
    localparam int AES256_NR        = 14;

endpackage

// File: rtl/keyschedule_sequencer_if.sv
// Key load/replay controls, round-key stream and key-expansion handshake
// of the round-key sequencer. The sequencer takes the slave side.
interface keyschedule_sequencer_if #(
    parameter int BLK_W     = 128,
    parameter int KEY_WORDS = 2,
    parameter int IDX_W     = 4
);
    logic                       key_load;
    logic [BLK_W*KEY_WORDS-1:0] key_in;
    logic                       key_replay;
    logic                       rk_valid;
    logic                       rk_ready;
    logic [BLK_W-1:0]           rk_data;
    logic [IDX_W-1:0]           rk_idx;
    logic                       rk_last;
    logic                       exp_req;
    logic                       exp_ack;
    logic [BLK_W-1:0]           exp_last;
    logic [BLK_W-1:0]           exp_prev;
    logic [IDX_W-1:0]           exp_idx;
    logic [BLK_W-1:0]           exp_result;
    logic                       busy;
    logic                       done;

    modport master (
        output key_load, key_in, key_replay, rk_ready, exp_ack, exp_result,
        input  rk_valid, rk_data, rk_idx, rk_last, exp_req, exp_last, exp_prev,
               exp_idx, busy, done
    );

    modport slave (
        input  key_load, key_in, key_replay, rk_ready, exp_ack, exp_result,
        output rk_valid, rk_data, rk_idx, rk_last, exp_req, exp_last, exp_prev,
               exp_idx, busy, done
    );
endinterface

// File: rtl/keysched_hist.sv
// History of the most recent round keys: entry 0 is the oldest, entry
// DEPTH-1 the newest. Parallel load for a (re)start, shift-in for a new key.
module keysched_hist #(
    parameter int BLK_W = 128,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [BLK_W*DEPTH-1:0] load_data,
    input  logic                   shift,
    input  logic [BLK_W-1:0]       shift_data,
    output logic [BLK_W-1:0]       newest,
    output logic [BLK_W-1:0]       oldest
);
    logic [BLK_W-1:0] hist_q [DEPTH];
    logic [BLK_W-1:0] hist_d [DEPTH];

    // Next history contents: load wins over shift, otherwise hold.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hist_d = hist_q;
        if (load) begin
            for (int j = 0; j < DEPTH; j++) begin
                // Word 0 sits in the MSBs of the key.
                hist_d[j] = load_data[BLK_W*(DEPTH-j)-1 -: BLK_W];
            end
        end else if (shift) begin
            for (int j = 0; j < DEPTH - 1; j++) begin
                hist_d[j] = hist_q[j+1];
            end
            hist_d[DEPTH-1] = shift_data;
        end
    end

    // History register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this storage is reset because the exp_last/exp_prev outputs must read 0 out of reset.
            hist_q <= '{default: '0};
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            hist_q <= hist_d;
        end
    end

    assign newest = hist_q[DEPTH-1];
    assign oldest = hist_q[0];
endmodule

// File: rtl/keyschedule_sequencer.sv
// Round-key sequencer: stores the cipher key, emits round keys 0..NR over a
// valid/ready stream and feeds an external expansion unit with the previous
// KEY_WORDS round keys. No cipher arithmetic happens here.
module keyschedule_sequencer
    import keysched_pkg::*;
#(
    parameter int BLK_W     = 128,
    parameter int KEY_WORDS = 2,
    parameter int NR        = 14,
    parameter int IDX_W     = $clog2(NR + 1)
) (
    input logic                    clk,
    input logic                    rst_n,
    keyschedule_sequencer_if.slave bus
);
    if (!(KEY_WORDS == AES128_KEY_WORDS || KEY_WORDS == AES256_KEY_WORDS) || NR < KEY_WORDS)
    begin : g_param_check
        $error("keyschedule_sequencer: KEY_WORDS must be 1 or 2 and NR >= KEY_WORDS");
    end

    state_e                     state_q, state_d;
    logic [BLK_W*KEY_WORDS-1:0] kstore_q, kstore_d;
    logic                       key_valid_q, key_valid_d;
    logic [BLK_W-1:0]           cur_q, cur_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       done_q, done_d;

    logic                       restart;
    logic [BLK_W*KEY_WORDS-1:0] restart_key;
    logic                       hist_shift;
    logic [BLK_W-1:0]           hist_newest;
    logic [BLK_W-1:0]           hist_oldest;

    keysched_hist #(
        .BLK_W (BLK_W),
        .DEPTH (KEY_WORDS)
    ) u_hist (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (restart),
        .load_data  (restart_key),
        .shift      (hist_shift),
        .shift_data (bus.exp_result),
        .newest     (hist_newest),
        .oldest     (hist_oldest)
    );

    // Next-state logic: restart (load beats replay) overrides the stream FSM,
    // which also drops any exp_ack arriving in the same cycle.
    always_comb begin
        state_d     = state_q;
        kstore_d    = kstore_q;
        key_valid_d = key_valid_q;
        cur_d       = cur_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        restart     = 1'b0;
        restart_key = bus.key_in;
        hist_shift  = 1'b0;

        if (bus.key_load) begin
            restart     = 1'b1;
            kstore_d    = bus.key_in;
            key_valid_d = 1'b1;
        end else if (bus.key_replay && key_valid_q) begin
            restart     = 1'b1;
            restart_key = kstore_q;
        end

        if (restart) begin
            cur_d   = restart_key[BLK_W*KEY_WORDS-1 -: BLK_W];
            idx_d   = '0;
            state_d = EMIT;
        end else begin
            case (state_q)
                EMIT: begin
                    if (bus.rk_ready) begin
                        if (idx_q == IDX_W'(NR)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (int'(idx_q) + 1 < KEY_WORDS) begin
                            // With at most two key words this is only idx 0 -> 1,
                            // and hist[1] is the newest entry.
                            cur_d = hist_newest;
                            idx_d = idx_q + 1'b1;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    if (bus.exp_ack) begin
                        cur_d      = bus.exp_result;
                        hist_shift = 1'b1;
                        state_d    = EMIT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kstore_q    <= '0;
            key_valid_q <= 1'b0;
            cur_q       <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            kstore_q    <= kstore_d;
            key_valid_q <= key_valid_d;
            cur_q       <= cur_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
        end
    end

    assign bus.rk_valid = (state_q == EMIT);
    assign bus.rk_data  = cur_q;
    assign bus.rk_idx   = idx_q;
    assign bus.rk_last  = (state_q == EMIT) && (idx_q == IDX_W'(NR));
    assign bus.exp_req  = (state_q == EXPAND);
    assign bus.exp_last = hist_newest;
    assign bus.exp_prev = hist_oldest;
    assign bus.exp_idx  = idx_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
endmodule
